avalon_aes_csr: RTL and testbench
=================================

Name: avalon_aes_csr

Overview:
Parametrised Avalon-MM slave CSR block that fronts the AES decryption core. It holds key and ciphertext words and launches the core with a one-cycle start pulse. It captures the plaintext on completion and reports busy/done/error/timeout status, with an interrupt and an operation cycle count. Registered read data (readLatency = 1), full byte-lane writes, and write protection while the core runs.

Parameters:
BLOCK_WORDS, 4, 32-bit words per key/message block (128-bit AES = 4); map offsets scale with it.
ADDR_W, 4, Avalon word-address width; must satisfy 2^ADDR_W >= 3*BLOCK_WORDS+4 (checked by elaboration assertion).
TIMEOUT_CYC, 1024, max cycles in WAIT before abort; 0 disables timeout.

Ports:
CLK  in  1  clock
RESET  in  1  reset
AVL_READ  in  1  Avalon read
AVL_WRITE  in  1  Avalon write
AVL_CS  in  1  chip select
AVL_BYTE_EN  in  4  byte enables
AVL_ADDR  in  ADDR_W  word address
AVL_WRITEDATA  in  32  write data
AVL_READDATA  out  32  read data, registered
AVL_IRQ  out  1  interrupt, level
CORE_START  out  1  one-cycle start pulse to AES core
CORE_DONE  in  1  core done level, held until next CORE_START
CORE_KEY  out  32*BLOCK_WORDS  key, word 0 in MSBs
CORE_MSG_ENC  out  32*BLOCK_WORDS  ciphertext, word 0 in MSBs
CORE_MSG_DEC  in  32*BLOCK_WORDS  plaintext, word 0 in MSBs
EXPORT_DATA  out  32  LED conduit

Behaviour:
- Reset: RESET, synchronous, active-high; clock CLK. All registers zero, state IDLE. AVL_READDATA=0, AVL_IRQ=0, CORE_START=0. Reset mid-operation aborts silently with no capture and no IRQ.
- Map (N=BLOCK_WORDS): KEY 0..N-1 RW; MSG N..2N-1 RW; RES 2N..3N-1 RO.
- CTRL 3N: bit0 START, write-only, reads 0.
- STATUS 3N+1: bit0 busy RO; bit1 done W1C; bit2 wr_err W1C; bit3 timeout W1C.
- IRQ_EN 3N+2: bit0 RW. CYCLES 3N+3: RO.
- Unmapped addresses read 0; writes to them are ignored.
- Writes (AVL_WRITE & AVL_CS): every asserted byte lane is updated in the same cycle. Writes to RO registers are ignored.
- Writes to KEY/MSG while busy are dropped and set wr_err.
- Reads (AVL_READ & AVL_CS in cycle t): AVL_READDATA is valid at t+1. When no read is active it holds 0. Read and write in the same cycle is not permitted (bus guarantee).
- FSM IDLE -> LAUNCH: on a CTRL write with byte lane 0 enabled and bit0=1.
- FSM LAUNCH -> WAIT: CORE_START=1 for exactly this cycle. CYCLES is cleared to 0 and the done and timeout bits are cleared.
- FSM WAIT -> IDLE on CORE_DONE=1: RES captures CORE_MSG_DEC and done is set, both on the same edge.
- FSM WAIT -> IDLE on timeout: when CYCLES reaches TIMEOUT_CYC-1 without CORE_DONE (TIMEOUT_CYC>0), timeout is set, done stays 0 and RES is unchanged.
- busy = (state != IDLE).
- CYCLES increments by 1 each WAIT cycle, saturates at 2^32-1, and holds after exit.
- A START write while busy is ignored and sets wr_err.
- A W1C write to done in the same cycle that a completion sets done: set wins. The same rule applies to timeout.
- AVL_IRQ = IRQ_EN[0] & (done | timeout), registered.
- EXPORT_DATA = {KEY[0][31:16], 8'hFF, KEY[N-1][7:0]}.
- CORE_KEY/CORE_MSG_ENC are driven directly from the registers and are stable throughout WAIT because of write protection.

Decomposition:
- Package aes_csr_pkg: state enum (IDLE, LAUNCH, WAIT); STATUS bit indices; functions off_key(N), off_msg(N), off_res(N), off_ctrl(N), off_status(N), off_irqen(N), off_cycles(N).
- Sub-module avl_be_reg: 32-bit register with per-byte-lane write enable and sync reset, instantiated for the KEY/MSG/IRQ_EN words.

Test Plan:
- Reset then read addrs 0..15 (N=4) -> all 0 at t+1; AVL_IRQ=0; EXPORT_DATA=32'h0000FF00.
- Write addr 0 data 32'hDEADBEEF BE=4'b0101, then BE=4'b1111 data 32'h12345678 to addr 3 -> addr 0 reads 32'h00AD00EF; EXPORT_DATA=32'h00ADFF78.
- Load key/msg, IRQ_EN=1, write CTRL=1; model asserts CORE_DONE 10 cycles after CORE_START with DEC=128'h0011..FF -> exactly one START pulse; RES 8..11 read 32'h00112233..; STATUS=32'h2; CYCLES=10; IRQ=1.
- Next, write STATUS=32'h2 -> done cleared, IRQ drops the following cycle.
- During WAIT write addr 4 = 32'hFFFFFFFF and CTRL=1 -> MSG unchanged, a single START seen, STATUS bit2=1 (busy also set).
- TIMEOUT_CYC=16, core never done -> after 16 WAIT cycles STATUS=32'h8, RES unchanged, IRQ=1 if enabled.
- Assert RESET while in WAIT, then CORE_DONE=1 -> no capture, STATUS=0, IRQ=0; a W1C of done in the cycle CORE_DONE arrives leaves done=1.

Source files
------------

// File: rtl/aes_csr_pkg.sv
// Shared definitions for the Avalon-MM CSR block in front of the AES
// decryption core.
// Contents:
//   - the FSM state encoding
//   - the bit positions inside the STATUS word
//   - register-map offset helpers, parametrised by BLOCK_WORDS (n)
package aes_csr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  // STATUS word bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_WR_ERR  = 2;
  localparam int STAT_TIMEOUT = 3;

  // Map layout: KEY block, MSG block, RES block, then four control words.
  function automatic int unsigned off_msg(input int unsigned n);
    return n;
  endfunction

  // The key block sits directly below the message block.
  function automatic int unsigned off_key(input int unsigned n);
    return off_msg(n) - n;
  endfunction

  function automatic int unsigned off_res(input int unsigned n);
    return 2 * n;
  endfunction

  function automatic int unsigned off_ctrl(input int unsigned n);
    return 3 * n;
  endfunction

  function automatic int unsigned off_status(input int unsigned n);
    return 3 * n + 1;
  endfunction

  function automatic int unsigned off_irqen(input int unsigned n);
    return 3 * n + 2;
  endfunction

  function automatic int unsigned off_cycles(input int unsigned n);
    return 3 * n + 3;
  endfunction

endpackage

// File: rtl/avl_be_reg.sv
// 32-bit CSR word with per-byte-lane write enables.
// Ports:
//   CLK, RESET : clock, synchronous active-high reset (clears to zero)
//   we         : write strobe for this word
//   byte_en    : byte lanes to update when we is high
//   wdata      : write data
//   q          : register contents
module avl_be_reg (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        we,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  output logic [31:0] q
);

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      q <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) q[8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/avalon_aes_csr.sv
// Avalon-MM slave CSR block fronting the AES decryption core.
// Holds the key and ciphertext words, launches the core with a one-cycle
// start pulse, captures the plaintext on completion and reports
// busy/done/wr_err/timeout with a level interrupt and a cycle count.
// Read data is registered (one-cycle latency). KEY/MSG are write-protected
// while the core runs.
// Ports:
//   CLK, RESET         : clock, synchronous active-high reset
//   AVL_*              : Avalon-MM slave (word addressed, byte enables)
//   AVL_READDATA       : registered read data, 0 when no read
//   AVL_IRQ            : level interrupt, IRQ_EN[0] & (done | timeout)
//   CORE_START         : one-cycle start pulse to the core
//   CORE_DONE          : core completion level
//   CORE_KEY/MSG_ENC   : key / ciphertext, word 0 in the MSBs
//   CORE_MSG_DEC       : plaintext from the core, word 0 in the MSBs
//   EXPORT_DATA        : LED conduit
module avalon_aes_csr
  import aes_csr_pkg::*;
#(
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      AVL_READ,
  input  logic                      AVL_WRITE,
  input  logic                      AVL_CS,
  input  logic [3:0]                AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]         AVL_ADDR,
  input  logic [31:0]               AVL_WRITEDATA,
  output logic [31:0]               AVL_READDATA,
  output logic                      AVL_IRQ,
  output logic                      CORE_START,
  input  logic                      CORE_DONE,
  output logic [32*BLOCK_WORDS-1:0] CORE_KEY,
  output logic [32*BLOCK_WORDS-1:0] CORE_MSG_ENC,
  input  logic [32*BLOCK_WORDS-1:0] CORE_MSG_DEC,
  output logic [31:0]               EXPORT_DATA
);

  if ((2 ** ADDR_W) < (3 * BLOCK_WORDS + 4)) begin : g_addr_w_check
    $error("ADDR_W too narrow for the register map of BLOCK_WORDS words");
  end

  localparam int unsigned N          = BLOCK_WORDS;
  localparam int unsigned OFF_KEY    = off_key(N);
  localparam int unsigned OFF_MSG    = off_msg(N);
  localparam int unsigned OFF_RES    = off_res(N);
  localparam int unsigned OFF_CTRL   = off_ctrl(N);
  localparam int unsigned OFF_STATUS = off_status(N);
  localparam int unsigned OFF_IRQEN  = off_irqen(N);
  localparam int unsigned OFF_CYCLES = off_cycles(N);
  // Value of CYCLES in the last WAIT cycle allowed before abort.
  localparam logic [31:0] TO_LAST    = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

  logic [31:0] addr;
  logic        wr;
  logic        rd;
  state_t      state;
  logic        busy;

  logic [31:0] key_q [BLOCK_WORDS];
  logic [31:0] msg_q [BLOCK_WORDS];
  logic [31:0] res_q [BLOCK_WORDS];
  logic [BLOCK_WORDS-1:0] key_we;
  logic [BLOCK_WORDS-1:0] msg_we;
  logic [31:0] irq_en_q;
  logic [31:0] cycles;

  logic done;
  logic wr_err;
  logic timeout;

  logic blk_wr;
  logic start_req;
  logic status_wr;
  logic err_set;
  logic done_set;
  logic to_set;
  logic [31:0] rd_mux;

  assign addr = 32'(AVL_ADDR);
  assign wr   = AVL_WRITE & AVL_CS;
  assign rd   = AVL_READ & AVL_CS;
  assign busy = (state != IDLE);

  // Any write into the KEY or MSG blocks (KEY starts at offset 0).
  assign blk_wr    = wr & (addr < 32'(OFF_RES));
  assign start_req = wr & (addr == 32'(OFF_CTRL)) & AVL_BYTE_EN[0] & AVL_WRITEDATA[0];
  assign status_wr = wr & (addr == 32'(OFF_STATUS)) & AVL_BYTE_EN[0];
  assign err_set   = busy & (blk_wr | start_req);
  assign done_set  = (state == WAIT) & CORE_DONE;
  assign to_set    = (TIMEOUT_CYC > 0) & (state == WAIT) & ~CORE_DONE & (cycles == TO_LAST);

  // Key / message words; dropped (and flagged via wr_err) while busy.
  for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_words
    assign key_we[g] = wr & ~busy & (addr == 32'(OFF_KEY) + 32'(g));
    assign msg_we[g] = wr & ~busy & (addr == 32'(OFF_MSG) + 32'(g));

    avl_be_reg u_key (
      .CLK     (CLK),
      .RESET   (RESET),
      .we      (key_we[g]),
      .byte_en (AVL_BYTE_EN),
      .wdata   (AVL_WRITEDATA),
      .q       (key_q[g])
    );

    avl_be_reg u_msg (
      .CLK     (CLK),
      .RESET   (RESET),
      .we      (msg_we[g]),
      .byte_en (AVL_BYTE_EN),
      .wdata   (AVL_WRITEDATA),
      .q       (msg_q[g])
    );

    assign CORE_KEY[32*(BLOCK_WORDS-1-g) +: 32]     = key_q[g];
    assign CORE_MSG_ENC[32*(BLOCK_WORDS-1-g) +: 32] = msg_q[g];
  end

  // Only bit 0 of IRQ_EN is implemented; upper bits are written as zero.
  avl_be_reg u_irq_en (
    .CLK     (CLK),
    .RESET   (RESET),
    .we      (wr & (addr == 32'(OFF_IRQEN))),
    .byte_en (AVL_BYTE_EN),
    .wdata   ({31'd0, AVL_WRITEDATA[0]}),
    .q       (irq_en_q)
  );

  // Control FSM with registered start pulse, cycle counter and result capture.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      CORE_START <= 1'b0;
      cycles     <= '0;
      // NOTE: the result words are a small register bank, not a RAM, so
      // clearing them in reset is cheap and keeps reads deterministic.
      for (int i = 0; i < BLOCK_WORDS; i++) res_q[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_req) begin
            state      <= LAUNCH;
            CORE_START <= 1'b1;
          end
        end
        LAUNCH: begin
          state      <= WAIT;
          CORE_START <= 1'b0;
          cycles     <= '0;
        end
        WAIT: begin
          if (cycles != '1) cycles <= cycles + 32'd1;
          if (CORE_DONE) begin
            state <= IDLE;
            for (int i = 0; i < BLOCK_WORDS; i++)
              res_q[i] <= CORE_MSG_DEC[32*(BLOCK_WORDS-1-i) +: 32];
          end else if (to_set) begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          CORE_START <= 1'b0;
        end
      endcase
    end
  end

  // Sticky status flags: a completion in the same cycle as a W1C wins.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      done    <= 1'b0;
      wr_err  <= 1'b0;
      timeout <= 1'b0;
      AVL_IRQ <= 1'b0;
    end else begin
      if (state == LAUNCH) begin
        done    <= 1'b0;
        timeout <= 1'b0;
      end else begin
        done    <= done_set | (done & ~(status_wr & AVL_WRITEDATA[STAT_DONE]));
        timeout <= to_set | (timeout & ~(status_wr & AVL_WRITEDATA[STAT_TIMEOUT]));
      end
      wr_err  <= err_set | (wr_err & ~(status_wr & AVL_WRITEDATA[STAT_WR_ERR]));
      AVL_IRQ <= irq_en_q[0] & (done | timeout);
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns rd_mux and no latch forms.
    rd_mux = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      if (addr == 32'(OFF_KEY) + 32'(i)) rd_mux = key_q[i];
      if (addr == 32'(OFF_MSG) + 32'(i)) rd_mux = msg_q[i];
      if (addr == 32'(OFF_RES) + 32'(i)) rd_mux = res_q[i];
    end
    if (addr == 32'(OFF_STATUS)) begin
      rd_mux[STAT_BUSY]    = busy;
      rd_mux[STAT_DONE]    = done;
      rd_mux[STAT_WR_ERR]  = wr_err;
      rd_mux[STAT_TIMEOUT] = timeout;
    end
    if (addr == 32'(OFF_IRQEN))  rd_mux = irq_en_q;
    if (addr == 32'(OFF_CYCLES)) rd_mux = cycles;
  end

  always_ff @(posedge CLK) begin
    if (RESET) AVL_READDATA <= '0;
    else       AVL_READDATA <= rd ? rd_mux : 32'd0;
  end

  assign EXPORT_DATA = {key_q[0][31:16], 8'hFF, key_q[BLOCK_WORDS-1][7:0]};

endmodule

// File: tb/tb_avalon_aes_csr.sv
// Directed bench for avalon_aes_csr (BLOCK_WORDS=4, ADDR_W=4, TIMEOUT_CYC=16).
// Read expectations go into a scoreboard queue when the read is issued and
// are popped when registered read data appears one cycle later. A small
// core model raises CORE_DONE a fixed delay after CORE_START.
module tb_avalon_aes_csr;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int TO = 16;

  logic           CLK = 1'b0;
  logic           RESET;
  logic           AVL_READ;
  logic           AVL_WRITE;
  logic           AVL_CS;
  logic [3:0]     AVL_BYTE_EN;
  logic [AW-1:0]  AVL_ADDR;
  logic [31:0]    AVL_WRITEDATA;
  logic [31:0]    AVL_READDATA;
  logic           AVL_IRQ;
  logic           CORE_START;
  logic           CORE_DONE;
  logic [32*N-1:0] CORE_KEY;
  logic [32*N-1:0] CORE_MSG_ENC;
  logic [32*N-1:0] CORE_MSG_DEC;
  logic [31:0]    EXPORT_DATA;

  avalon_aes_csr #(
    .BLOCK_WORDS (N),
    .ADDR_W      (AW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .AVL_READ      (AVL_READ),
    .AVL_WRITE     (AVL_WRITE),
    .AVL_CS        (AVL_CS),
    .AVL_BYTE_EN   (AVL_BYTE_EN),
    .AVL_ADDR      (AVL_ADDR),
    .AVL_WRITEDATA (AVL_WRITEDATA),
    .AVL_READDATA  (AVL_READDATA),
    .AVL_IRQ       (AVL_IRQ),
    .CORE_START    (CORE_START),
    .CORE_DONE     (CORE_DONE),
    .CORE_KEY      (CORE_KEY),
    .CORE_MSG_ENC  (CORE_MSG_ENC),
    .CORE_MSG_DEC  (CORE_MSG_DEC),
    .EXPORT_DATA   (EXPORT_DATA)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Core model: done rises so that it is visible 10 cycles after the START
  // cycle (mode 1) or never (mode 0); it drops when the next START arrives.
  int          model_mode = 0;
  int unsigned model_cnt  = 0;
  logic        model_done = 1'b0;
  logic        force_done = 1'b0;
  assign CORE_DONE    = model_done | force_done;
  assign CORE_MSG_DEC = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  always @(posedge CLK) begin
    if (RESET) begin
      model_done <= 1'b0;
      model_cnt  <= 0;
    end else if (CORE_START) begin
      model_done <= 1'b0;
      model_cnt  <= (model_mode == 1) ? 9 : 0;
    end else if (model_cnt == 1) begin
      model_done <= 1'b1;
      model_cnt  <= 0;
    end else if (model_cnt > 1) begin
      model_cnt  <= model_cnt - 1;
    end
  end

  int start_cnt = 0;
  always @(posedge CLK) if (CORE_START) start_cnt <= start_cnt + 1;

  // Scoreboard for registered reads.
  typedef struct packed {
    logic [31:0] exp;
    logic [7:0]  addr;
  } rd_exp_t;
  rd_exp_t sb_q[$];
  rd_exp_t sb_e;
  logic    rd_seen = 1'b0;

  always @(posedge CLK) rd_seen <= AVL_READ & AVL_CS & ~RESET;

  always @(negedge CLK) begin
    if (rd_seen) begin
      if (sb_q.size() == 0) begin
        check("sb_occupancy", 128'(sb_q.size()), 128'd1);
      end else begin
        sb_e = sb_q.pop_front();
        check($sformatf("rd@%0d", sb_e.addr), 128'(AVL_READDATA), 128'(sb_e.exp));
      end
    end
  end

  // Bus tasks are called at a negedge and return at the next negedge.
  task automatic bus_write(input int a, input logic [31:0] d, input logic [3:0] be);
    AVL_WRITE     = 1'b1;
    AVL_CS        = 1'b1;
    AVL_ADDR      = AW'(a);
    AVL_WRITEDATA = d;
    AVL_BYTE_EN   = be;
    @(negedge CLK);
    AVL_WRITE     = 1'b0;
    AVL_CS        = 1'b0;
    AVL_BYTE_EN   = 4'hF;
  endtask

  task automatic bus_read(input int a, input logic [31:0] exp);
    sb_q.push_back('{exp: exp, addr: 8'(a)});
    AVL_READ = 1'b1;
    AVL_CS   = 1'b1;
    AVL_ADDR = AW'(a);
    @(negedge CLK);
    AVL_READ = 1'b0;
    AVL_CS   = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!CORE_START && n < 8) begin
      @(negedge CLK);
      n++;
    end
    check(tag, 128'(CORE_START), 128'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!CORE_DONE && n < 30) begin
      @(negedge CLK);
      n++;
    end
    check(tag, 128'(CORE_DONE), 128'd1);
  endtask

  logic [31:0] key_w [N];
  logic [31:0] msg_w [N];
  logic [31:0] dec_w [N];
  int          start_base;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    key_w = '{32'h2B7E1516, 32'h28AED2A6, 32'hABF71588, 32'h09CF4F3C};
    msg_w = '{32'h3925841D, 32'h02DC09FB, 32'hDC118597, 32'h196A0B32};
    dec_w = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

    RESET = 1'b1;
    AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_CS = 1'b0;
    AVL_BYTE_EN = 4'hF; AVL_ADDR = '0; AVL_WRITEDATA = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    // Reset state
    check("rst_irq",    128'(AVL_IRQ),      128'd0);
    check("rst_start",  128'(CORE_START),   128'd0);
    check("rst_rdata",  128'(AVL_READDATA), 128'd0);
    check("rst_export", 128'(EXPORT_DATA),  128'h0000FF00);
    for (int i = 0; i < 16; i++) bus_read(i, 32'd0);

    // Byte-lane writes
    bus_write(0, 32'hDEADBEEF, 4'b0101);
    bus_write(3, 32'h12345678, 4'b1111);
    bus_read(0, 32'h00AD00EF);
    bus_read(3, 32'h12345678);
    check("export_bytes", 128'(EXPORT_DATA), 128'h00ADFF78);

    // Load key/message; RO and reserved bits ignore writes
    for (int i = 0; i < N; i++) bus_write(i, key_w[i], 4'hF);
    for (int i = 0; i < N; i++) bus_write(N + i, msg_w[i], 4'hF);
    check("core_key", CORE_KEY,     {key_w[0], key_w[1], key_w[2], key_w[3]});
    check("core_msg", CORE_MSG_ENC, {msg_w[0], msg_w[1], msg_w[2], msg_w[3]});
    bus_write(14, 32'hFFFFFFFF, 4'hF);
    bus_read(14, 32'd1);
    bus_write(8, 32'h55555555, 4'hF);
    bus_write(15, 32'h00000007, 4'hF);
    bus_read(8, 32'd0);
    bus_read(15, 32'd0);
    bus_read(6, msg_w[2]);

    // Normal operation, done 10 cycles after START
    model_mode = 1;
    start_base = start_cnt;
    bus_write(12, 32'd1, 4'hF);
    repeat (20) @(negedge CLK);
    check("start_once_1", 128'(start_cnt - start_base), 128'd1);
    for (int i = 0; i < N; i++) bus_read(2 * N + i, dec_w[i]);
    bus_read(13, 32'h2);
    bus_read(15, 32'd10);
    bus_read(12, 32'd0);
    check("irq_done", 128'(AVL_IRQ), 128'd1);

    // W1C done: IRQ drops one cycle after the clear
    bus_write(13, 32'h2, 4'hF);
    check("irq_hold", 128'(AVL_IRQ), 128'd1);
    @(negedge CLK);
    check("irq_drop", 128'(AVL_IRQ), 128'd0);
    bus_read(13, 32'h0);

    // Write protection while busy
    start_base = start_cnt;
    bus_write(12, 32'd1, 4'hF);
    wait_start("start_seen_2");
    @(negedge CLK);
    bus_write(4, 32'hFFFFFFFF, 4'hF);
    bus_write(12, 32'd1, 4'hF);
    bus_read(13, 32'h5);
    bus_read(4, msg_w[0]);
    repeat (15) @(negedge CLK);
    check("start_once_2", 128'(start_cnt - start_base), 128'd1);
    bus_read(13, 32'h6);
    bus_read(4, msg_w[0]);
    bus_write(13, 32'hE, 4'hF);
    bus_read(13, 32'h0);

    // Timeout: core never completes
    model_mode = 0;
    bus_write(12, 32'd1, 4'hF);
    repeat (25) @(negedge CLK);
    bus_read(13, 32'h8);
    bus_read(15, 32'd16);
    bus_read(8, dec_w[0]);
    check("irq_timeout", 128'(AVL_IRQ), 128'd1);
    bus_write(13, 32'h8, 4'hF);
    bus_read(13, 32'h0);

    // Completion and W1C of done in the same cycle: set wins
    model_mode = 1;
    bus_write(12, 32'd1, 4'hF);
    wait_start("start_seen_3");
    wait_done("done_seen_3");
    bus_write(13, 32'h2, 4'hF);
    bus_read(13, 32'h2);
    bus_read(15, 32'd10);

    // Reset in WAIT aborts silently; late CORE_DONE is not captured
    bus_write(13, 32'h2, 4'hF);
    model_mode = 0;
    bus_write(12, 32'd1, 4'hF);
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    force_done = 1'b1;
    repeat (3) @(negedge CLK);
    bus_read(13, 32'h0);
    bus_read(8, 32'd0);
    check("rst_wait_irq",    128'(AVL_IRQ),     128'd0);
    check("rst_wait_start",  128'(CORE_START),  128'd0);
    check("rst_wait_export", 128'(EXPORT_DATA), 128'h0000FF00);
    force_done = 1'b0;

    repeat (2) @(negedge CLK);
    check("sb_drain", 128'(sb_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
